// File: rtl/spram_arbiter_pm.sv
// spram_arbiter_pm: round-robin sharing of one 16Kx16 SPRAM between two requesters, with standby/sleep power management
module spram_arbiter_pm #(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [13:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [3:0]  a_mask,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [13:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [3:0]  b_mask,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  input  logic        sleep_req,
  output logic        sleep_ack,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  output logic        ram_cs,
  output logic        ram_standby,
  output logic        ram_sleep,
  output logic        ram_poweroff_n,
  input  logic [15:0] ram_dout
);
  typedef enum logic [1:0] {ACTIVE, STBY, WAKE, SLP} state_t;
  localparam int IW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
  localparam int WW = WAKE_CYCLES > 1 ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES > 0 ? IDLE_CYCLES - 1 : 0);
  localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES > 0 ? WAKE_CYCLES - 1 : 0);
  localparam logic IDLE_EN = IDLE_CYCLES != 0;
  state_t state, state_nx;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;
  logic rr_ptr, allow, any_req, rd_pend, idle_hit;
  always_comb begin
    allow = resetn && state == ACTIVE && !sleep_req;
    a_gnt = allow && a_req && (!b_req || !rr_ptr);
    b_gnt = allow && b_req && (!a_req || rr_ptr);
    any_req = a_req || b_req;
    rd_pend = (a_gnt && !a_we) || (b_gnt && !b_we);
    idle_hit = IDLE_EN && !any_req && idle_cnt == IDLE_MAX && !rd_pend;
    state_nx = state;
    unique case (state)
      ACTIVE: state_nx = sleep_req ? (rd_pend ? ACTIVE : SLP) : idle_hit ? STBY : ACTIVE;
      STBY:   state_nx = sleep_req ? SLP : any_req ? WAKE : STBY;
      WAKE:   state_nx = sleep_req ? SLP : wake_cnt == WAKE_MAX ? ACTIVE : WAKE;
      SLP:    state_nx = sleep_req ? SLP : WAKE;
      default: state_nx = ACTIVE;
    endcase
  end
  assign ram_cs = a_gnt || b_gnt;
  assign ram_addr = b_gnt ? b_addr : a_addr;
  assign ram_din = b_gnt ? b_wdata : a_wdata;
  assign ram_wren = a_gnt ? a_we : b_gnt && b_we;
  assign ram_maskwren = !ram_wren ? 4'h0 : b_gnt ? b_mask : a_mask;
  assign a_rdata = ram_dout;
  assign b_rdata = ram_dout;
  assign ram_poweroff_n = 1'b1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      rr_ptr <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      ram_standby <= 1'b0;
      ram_sleep <= 1'b0;
      sleep_ack <= 1'b0;
    end else begin
      state <= state_nx;
      idle_cnt <= (state != ACTIVE || any_req) ? '0 : idle_cnt == IDLE_MAX ? idle_cnt : idle_cnt + IW'(1);
      wake_cnt <= (state == WAKE && state_nx == WAKE) ? wake_cnt + WW'(1) : '0;
      rr_ptr <= a_gnt ? 1'b1 : b_gnt ? 1'b0 : rr_ptr;
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      ram_standby <= state_nx == STBY;
      ram_sleep <= state_nx == SLP;
      sleep_ack <= state_nx == SLP;
    end
  end
endmodule

// File: tb/tb_spram_arbiter_pm.sv
// tb_spram_arbiter_pm: vector table plus hand sequences, read data checked through a per-side scoreboard
module tb_spram_arbiter_pm;
  logic clk = 0, resetn = 0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0, sleep_req = 0;
  logic [13:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic [3:0] a_mask = 0, b_mask = 0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, sleep_ack;
  logic [15:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [13:0] ram_addr;
  logic [3:0] ram_maskwren;
  logic ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff_n;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  typedef struct { bit side; bit we; logic [13:0] addr; logic [15:0] wdata; logic [3:0] mask; logic [15:0] exp; } vec_t;
  typedef struct { logic [15:0] data; int cyc; } sb_t;
  sb_t qa[$], qb[$];
  vec_t v[12];
  logic [15:0] mem [0:16383];

  spram_arbiter_pm #(.IDLE_CYCLES(4), .WAKE_CYCLES(3)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sleep_req(sleep_req), .sleep_ack(sleep_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_maskwren(ram_maskwren), .ram_wren(ram_wren),
    .ram_cs(ram_cs), .ram_standby(ram_standby), .ram_sleep(ram_sleep),
    .ram_poweroff_n(ram_poweroff_n), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural SPRAM: nibble-masked write, one-cycle registered read
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wren) begin
        for (int n = 0; n < 4; n++)
          if (ram_maskwren[n]) mem[ram_addr][4*n +: 4] <= ram_din[4*n +: 4];
      end else ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit side, input logic [15:0] d);
    sb_t e;
    e.data = d;
    e.cyc = cyc + 1;
    if (side) qb.push_back(e); else qa.push_back(e);
  endtask

  task automatic sb_side(input bit side, input logic rv, input logic [15:0] rd);
    sb_t e;
    int sz;
    sz = side ? qb.size() : qa.size();
    if (rv) begin
      if (sz == 0) chk(side ? "b_rvalid_unexpected" : "a_rvalid_unexpected", 1, 0);
      else begin
        e = side ? qb.pop_front() : qa.pop_front();
        chk(side ? "b_rdata" : "a_rdata", rd, e.data);
        chk(side ? "b_rvalid_cycle" : "a_rvalid_cycle", cyc, e.cyc);
      end
    end else if (sz != 0) begin
      e = side ? qb[0] : qa[0];
      if (e.cyc <= cyc) begin
        chk(side ? "b_rvalid_missing" : "a_rvalid_missing", 0, 1);
        if (side) void'(qb.pop_front()); else void'(qa.pop_front());
      end
    end
  endtask

  always @(negedge clk) if (resetn) begin
    sb_side(0, a_rvalid, a_rdata);
    sb_side(1, b_rvalid, b_rdata);
  end

  task automatic access(input vec_t t);
    bit got;
    got = 0;
    if (t.side) begin b_req = 1; b_we = t.we; b_addr = t.addr; b_wdata = t.wdata; b_mask = t.mask; end
    else begin a_req = 1; a_we = t.we; a_addr = t.addr; a_wdata = t.wdata; a_mask = t.mask; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (t.side ? b_gnt : a_gnt) begin
        got = 1;
        chk("other_gnt", t.side ? a_gnt : b_gnt, 0);
        chk("ram_cs", ram_cs, 1);
        chk("ram_addr", ram_addr, t.addr);
        chk("ram_wren", ram_wren, t.we);
        chk("ram_maskwren", ram_maskwren, t.we ? t.mask : 4'h0);
        if (t.we) chk("ram_din", ram_din, t.wdata);
        else push(t.side, t.exp);
      end
    end
    chk("gnt_timeout", got, 1);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
  endtask

  initial begin
    bit slept;
    v[0]  = '{0, 1, 14'h0010, 16'hBEEF, 4'hF, 16'h0};
    v[1]  = '{0, 0, 14'h0010, 16'h0,    4'h0, 16'hBEEF};
    v[2]  = '{1, 1, 14'h3FFF, 16'h1234, 4'hF, 16'h0};
    v[3]  = '{1, 1, 14'h3FFF, 16'hFFFF, 4'h1, 16'h0};
    v[4]  = '{0, 0, 14'h3FFF, 16'h0,    4'h0, 16'h123F};
    v[5]  = '{1, 0, 14'h0010, 16'h0,    4'h0, 16'hBEEF};
    v[6]  = '{0, 1, 14'h0020, 16'h0000, 4'hF, 16'h0};
    v[7]  = '{0, 1, 14'h0020, 16'hAAAA, 4'hA, 16'h0};
    v[8]  = '{1, 0, 14'h0020, 16'h0,    4'h0, 16'hA0A0};
    v[9]  = '{1, 1, 14'h1000, 16'h5555, 4'hF, 16'h0};
    v[10] = '{1, 1, 14'h1000, 16'h5678, 4'h0, 16'h0};
    v[11] = '{0, 0, 14'h1000, 16'h0,    4'h0, 16'h5555};
    a_req = 1; b_req = 1; a_we = 1; b_we = 1;
    repeat (2) @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_power", {ram_standby, ram_sleep, sleep_ack}, 0);
    chk("rst_poweroff_n", ram_poweroff_n, 1);
    @(posedge clk); #1;
    resetn = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    for (int i = 0; i < 12; i++) access(v[i]);
    // four request-free cycles enter standby, then a B request wakes it
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("idle_standby", ram_standby, k == 5);
    end
    @(posedge clk); #1;
    b_req = 1; b_we = 0; b_addr = 14'h3FFF;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("wake_b_gnt", b_gnt, k == 4);
      chk("wake_standby", ram_standby, k == 0);
      if (k == 4) push(1, 16'h123F);
    end
    @(posedge clk); #1;
    b_req = 0;
    // sleep requested right after an A read grant
    a_req = 1; a_we = 0; a_addr = 14'h0010;
    @(negedge clk);
    chk("slp_a_gnt", a_gnt, 1);
    if (a_gnt) push(0, 16'hBEEF);
    @(posedge clk); #1;
    a_req = 0; sleep_req = 1; b_req = 1; b_we = 0; b_addr = 14'h0020;
    @(negedge clk);
    chk("slp_a_rvalid", a_rvalid, 1);
    chk("slp_b_gnt", b_gnt, 0);
    slept = 0;
    for (int k = 0; k < 3 && !slept; k++) begin
      @(negedge clk);
      chk("slp_b_gnt", b_gnt, 0);
      slept = ram_sleep && sleep_ack;
    end
    chk("slp_entered", slept, 1);
    repeat (3) begin
      @(negedge clk);
      chk("slp_hold_b_gnt", b_gnt, 0);
      chk("slp_hold_ack", {sleep_ack, ram_sleep, ram_standby}, 3'b110);
    end
    @(posedge clk); #1;
    sleep_req = 0;
    @(negedge clk);
    chk("slp_ack_still", sleep_ack, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("rel_b_gnt", b_gnt, k == 4);
      chk("rel_ack", {sleep_ack, ram_sleep}, 0);
      if (k == 4 && b_gnt) push(1, 16'hA0A0);
    end
    @(posedge clk); #1;
    b_req = 0;
    repeat (2) @(negedge clk);
    // fresh reset so round-robin starts A-preferred
    @(posedge clk); #1;
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    a_req = 1; a_we = 0; a_addr = 14'h0010;
    b_req = 1; b_we = 0; b_addr = 14'h3FFF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_a_gnt", a_gnt, k % 2 == 0);
      chk("rr_b_gnt", b_gnt, k % 2 == 1);
      chk("rr_ram_cs", ram_cs, 1);
      if (a_gnt) push(0, 16'hBEEF);
      if (b_gnt) push(1, 16'h123F);
    end
    @(negedge clk);
    chk("mid_b_rvalid_pre", b_rvalid, 1);
    #1 resetn = 0;
    #1;
    chk("mid_gnts", {a_gnt, b_gnt}, 0);
    chk("mid_ram_cs", ram_cs, 0);
    chk("mid_ram_wren", ram_wren, 0);
    chk("mid_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("mid_power", {ram_standby, ram_sleep, sleep_ack}, 0);
    qa.delete(); qb.delete();
    repeat (2) begin
      @(negedge clk);
      chk("mid_hold_gnts", {a_gnt, b_gnt, ram_cs}, 0);
    end
    @(posedge clk); #1;
    resetn = 1; a_req = 0; b_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rvalid", {a_rvalid, b_rvalid}, 0);
    end
    chk("sb_a_empty", qa.size(), 0);
    chk("sb_b_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
